// File: rtl/cskip_seq_adder_pkg.sv
// Shared types and constants for the sequential carry-skip adder.
package cskip_seq_adder_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold the value n-1 (the last slice index), at least 1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cskip_seq_adder_cskip16_cin.sv
// 16-bit carry-skip adder slice: four 4-bit ripple groups, each group's
// carry-out bypassed by its carry-in when every bit in the group propagates.
module cskip16_cin
    import cskip_seq_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int GRP_W = 4;
    localparam int NGRP  = SLICE_W / GRP_W;

    logic c;   // carry entering the current group
    logic rc;  // ripple carry inside the current group
    logic gp;  // group propagate
    logic pb;  // bit propagate

    // Ripple each group bit by bit, then pick skip or ripple carry for the next group.
    always_comb begin
        sum = '0;
        c   = cin;
        rc  = 1'b0;
        gp  = 1'b0;
        pb  = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            rc = c;
            gp = 1'b1;
            for (int i = 0; i < GRP_W; i++) begin
                pb                = a[GRP_W*g+i] ^ b[GRP_W*g+i];
                sum[GRP_W*g+i]    = pb ^ rc;
                rc                = (a[GRP_W*g+i] & b[GRP_W*g+i]) | (pb & rc);
                gp                = gp & pb;
            end
            c = gp ? c : rc;
        end
        cout = c;
    end

endmodule

// File: rtl/cskip_seq_adder.sv
// Sequential W-bit adder: one 16-bit carry-skip slice is reused NSLICE times,
// least significant slice first, with the carry held in a register between steps.
module cskip_seq_adder
    import cskip_seq_adder_pkg::*;
#(
    parameter  int NSLICE = 4,
    localparam int W      = SLICE_W * NSLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);

    localparam int            CW   = cnt_w(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t                           state;
    logic [CW-1:0]                    cnt;
    logic                             carry;
    logic [NSLICE-1:0][SLICE_W-1:0]   a_q;
    logic [NSLICE-1:0][SLICE_W-1:0]   b_q;
    logic [NSLICE-1:0][SLICE_W-1:0]   sum_q;

    logic [SLICE_W-1:0]               sa;
    logic [SLICE_W-1:0]               sb;
    logic [SLICE_W-1:0]               ss;
    logic                             sc;

    // Counter-driven mux feeds the current slice of both operands to the adder.
    assign sa = a_q[cnt];
    assign sb = b_q[cnt];

    cskip16_cin u_slice (
        .a    (sa),
        .b    (sb),
        .cin  (carry),
        .sum  (ss),
        .cout (sc)
    );

    assign out_sum  = sum_q;
    assign out_cout = carry;

    // Control FSM plus operand/result/carry registers; handshake flags are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        carry    <= in_cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt] <= ss;
                    carry      <= sc;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cskip_seq_adder.sv
// Bench for cskip_seq_adder: transaction-level model plus directed literal cases.
module tb_cskip_seq_adder;

    localparam int NSLICE = 4;
    localparam int W      = 16 * NSLICE;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;
    bit rnd     = 0;

    cskip_seq_adder #(.NSLICE(NSLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: accept when free, result due NSLICE edges later, held until taken.
    bit           m_busy;
    bit           m_valid;
    int           m_wait;
    logic [W:0]   m_res;
    int           n_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_valid = 0;
            m_wait  = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                m_busy  = 0;
                n_done++;
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1;
        end else if (in_valid) begin
            m_busy = 1;
            m_wait = NSLICE;
            m_res  = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            if (!rst_n) begin
                chk("rst in_ready", in_ready, 1);
                chk("rst out_valid", out_valid, 0);
                chk("rst out_sum", out_sum, 0);
                chk("rst out_cout", out_cout, 0);
            end else begin
                chk("in_ready", in_ready, !m_busy);
                chk("out_valid", out_valid, m_valid);
                if (m_valid) begin
                    chk("out_sum", out_sum, m_res[W-1:0]);
                    chk("out_cout", out_cout, m_res[W]);
                end
            end
        end
    end

    // Random consumer readiness during the random phase.
    always @(posedge clk) begin
        if (rnd) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // One directed operation with literal expectations; optional back-pressure and operand disturbance.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input int bp, input bit disturb);
        int k;
        int lat;
        logic [W-1:0] held;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = 1'b0;
        k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk({nm, " ready timeout"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (disturb) begin
                in_a     = ~in_a;
                in_b     = in_b ^ {$urandom, $urandom};
                in_cin   = ~in_cin;
                in_valid = (lat == 1);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({nm, " latency"}, lat, NSLICE);
        chk({nm, " sum"}, out_sum, es);
        chk({nm, " cout"}, out_cout, ec);
        held = out_sum;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({nm, " bp valid"}, out_valid, 1);
            chk({nm, " bp sum"}, out_sum, held);
            chk({nm, " bp in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " idle in_ready"}, in_ready, 1);
        chk({nm, " idle out_valid"}, out_valid, 0);
        @(posedge clk); #1;
        chk({nm, " no 2nd op"}, in_ready, 1);
    endtask

    initial begin
        int k;
        bit acc;
        int base;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        #1 started = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_sum", out_sum, 0);
        rst_n = 1'b1;

        // First transfer right at the first edge after release.
        run_op("basic", 64'd998, 64'd128, 1'b0, 64'd1126, 1'b0, 0, 0);
        run_op("xslice", 64'd9998, 64'd9028, 1'b0, 64'h4A52, 1'b0, 0, 0);
        run_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 0, 0);
        run_op("bp", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1,
               64'h0001_0000_0001_0001, 1'b0, 5, 0);
        run_op("disturb", 64'd999909989998, 64'd769028, 1'b0, 64'd999910759026, 1'b0, 0, 1);
        run_op("topcarry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 64'd1, 1'b1, 0, 0);

        // Reset while in RUN at count 2.
        in_a = 64'h1234; in_b = 64'h4321; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        chk("abort out_sum", out_sum, 0);
        chk("abort out_cout", out_cout, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("after rst", 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001, 1'b0,
               64'h0000_0000_0002_0000, 1'b0, 0, 0);

        // Back-to-back random traffic; the compare process checks every result.
        base = n_done;
        rnd  = 1;
        for (int t = 0; t < 1000; t++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: begin ra = '1; rb = rb & 64'hF; end
                1: rb = ~ra;
                default: ;
            endcase
            in_a = ra; in_b = rb; in_cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            k = 0;
            do begin
                acc = in_ready;
                @(posedge clk); #1;
                k++;
            end while (!acc && k < 100);
            if (!acc) begin
                chk("random accept timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        k = 0;
        while (n_done - base < 1000 && k < 200) begin @(posedge clk); #1; k++; end
        rnd = 0;
        chk("random completions", n_done - base, 1000);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
